// File: rtl/dcsk_tx_ctrl.sv
// DCSK transmitter control: frame handshake, preamble/data/guard sequencing,
// chip and bit counters, and modulator strobes for the reference/information halves.
module dcsk_tx_ctrl #(
    parameter int unsigned CHIPS         = 16,
    parameter int unsigned LEN_W         = 10,
    parameter int unsigned PREAMBLE_BITS = 0,
    parameter int unsigned GUARD_CHIPS   = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_frame_valid,
    input  logic [LEN_W-1:0]               i_frame_len,
    input  logic                           i_abort,
    output logic                           o_frame_ready,
    output logic                           o_load_msg,
    output logic                           o_shift_msg_bit,
    output logic                           o_shift_chaos_bit,
    output logic                           o_ref_half,
    output logic                           o_force_one,
    output logic                           o_is_sending,
    output logic                           o_frame_done,
    output logic [$clog2(2*CHIPS)-1:0]     o_chip_ctr,
    output logic [LEN_W-1:0]               o_bit_ctr
);

    localparam int unsigned CHIP_W     = $clog2(2*CHIPS);
    localparam int unsigned PRE_W      = 8;
    localparam int unsigned GUARD_W    = 16;
    localparam int unsigned SYM_LAST   = 2*CHIPS - 1;
    localparam bit          HAS_PRE    = (PREAMBLE_BITS > 0);
    localparam bit          HAS_GUARD  = (GUARD_CHIPS > 0);
    localparam int unsigned PRE_LAST   = HAS_PRE   ? PREAMBLE_BITS - 1 : 0;
    localparam int unsigned GUARD_LAST = HAS_GUARD ? GUARD_CHIPS - 1   : 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_SEND     = 2'd2,
        S_GUARD    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CHIP_W-1:0]    chip_q;
    logic [LEN_W-1:0]     bit_q;
    logic [LEN_W-1:0]     len_q;
    logic [PRE_W-1:0]     pre_q;
    logic [GUARD_W-1:0]   guard_q;

    logic   sym_end;
    logic   on_air;
    state_t abort_dest;
    state_t start_dest;

    assign sym_end    = (chip_q == CHIP_W'(SYM_LAST));
    assign on_air     = (state_q == S_PREAMBLE) || (state_q == S_SEND);
    assign abort_dest = HAS_GUARD ? S_GUARD : S_IDLE;
    assign start_dest = HAS_PRE ? S_PREAMBLE : S_SEND;

    assign o_ref_half        = on_air && (chip_q < CHIP_W'(CHIPS));
    assign o_shift_chaos_bit = o_ref_half;
    assign o_chip_ctr        = chip_q;
    assign o_bit_ctr         = bit_q;

    // State, counters and captured frame length
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            chip_q  <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            pre_q   <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            if (o_load_msg || (state_d != state_q)) begin
                chip_q  <= '0;
                bit_q   <= '0;
                pre_q   <= '0;
                guard_q <= '0;
            end else begin
                if (state_q != S_IDLE) begin
                    chip_q <= sym_end ? '0 : chip_q + CHIP_W'(1);
                end
                if ((state_q == S_PREAMBLE) && sym_end) begin
                    pre_q <= pre_q + PRE_W'(1);
                end
                if (o_shift_msg_bit) begin
                    bit_q <= bit_q + LEN_W'(1);
                end
                if (state_q == S_GUARD) begin
                    guard_q <= guard_q + GUARD_W'(1);
                end
            end
            if (o_load_msg) begin
                len_q <= i_frame_len;
            end
        end
    end

    // Next state and control strobes
    always_comb begin
        state_d         = state_q;
        o_frame_ready   = 1'b0;
        o_load_msg      = 1'b0;
        o_shift_msg_bit = 1'b0;
        o_force_one     = 1'b0;
        o_is_sending    = 1'b0;
        o_frame_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_frame_ready = 1'b1;
                if (i_frame_valid) begin
                    o_load_msg = 1'b1;
                    state_d    = start_dest;
                end
            end
            S_PREAMBLE: begin
                o_force_one  = 1'b1;
                o_is_sending = 1'b1;
                if (i_abort) begin
                    o_frame_done = 1'b1;
                    state_d      = abort_dest;
                end else if (sym_end && (pre_q == PRE_W'(PRE_LAST))) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                o_is_sending = 1'b1;
                if (i_abort) begin
                    o_frame_done = 1'b1;
                    state_d      = abort_dest;
                end else if (sym_end) begin
                    if (bit_q != len_q) begin
                        o_shift_msg_bit = 1'b1;
                    end else begin
                        o_frame_done = 1'b1;
                        if (HAS_GUARD) begin
                            state_d = S_GUARD;
                        end else begin
                            // Last chip doubles as an accept slot for gapless frames
                            o_frame_ready = 1'b1;
                            if (i_frame_valid) begin
                                o_load_msg = 1'b1;
                                state_d    = start_dest;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_GUARD: begin
                if (guard_q == GUARD_W'(GUARD_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcsk_tx_ctrl.sv
// Directed self-checking bench for dcsk_tx_ctrl: plain config (A) and preamble+guard config (B).
module tb_dcsk_tx_ctrl;

    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] frame_len;
    logic       abort;

    logic       valid_a, ready_a, load_a, shift_a, chaos_a, ref_a, force_a, send_a, done_a;
    logic [2:0] chip_a;
    logic [9:0] bit_a;
    logic       valid_b, ready_b, load_b, shift_b, chaos_b, ref_b, force_b, send_b, done_b;
    logic [2:0] chip_b;
    logic [9:0] bit_b;

    int n_checks = 0;
    int n_fail   = 0;

    int r_send, r_shift, r_first_shift, r_last_shift, r_done, r_last_done, r_done_bit, r_load, r_ref_err;

    always #5 clk = ~clk;

    dcsk_tx_ctrl #(.CHIPS(CH), .LEN_W(10), .PREAMBLE_BITS(0), .GUARD_CHIPS(0)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(valid_a), .i_frame_len(frame_len),
        .i_abort(abort), .o_frame_ready(ready_a), .o_load_msg(load_a),
        .o_shift_msg_bit(shift_a), .o_shift_chaos_bit(chaos_a), .o_ref_half(ref_a),
        .o_force_one(force_a), .o_is_sending(send_a), .o_frame_done(done_a),
        .o_chip_ctr(chip_a), .o_bit_ctr(bit_a)
    );

    dcsk_tx_ctrl #(.CHIPS(CH), .LEN_W(10), .PREAMBLE_BITS(2), .GUARD_CHIPS(5)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(valid_b), .i_frame_len(frame_len),
        .i_abort(abort), .o_frame_ready(ready_b), .o_load_msg(load_b),
        .o_shift_msg_bit(shift_b), .o_shift_chaos_bit(chaos_b), .o_ref_half(ref_b),
        .o_force_one(force_b), .o_is_sending(send_b), .o_frame_done(done_b),
        .o_chip_ctr(chip_b), .o_bit_ctr(bit_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one frame to A and confirm it is loaded
    task automatic accept_a(input logic [9:0] len, input string tag);
        @(posedge clk); #1;
        valid_a   = 1'b1;
        frame_len = len;
        @(negedge clk);
        check_eq(tag, 32'(load_a), 32'd1);
    endtask

    // Run A for n cycles after an accept; cycle 1 is the first chip
    task automatic run_a(input int n, input int valid_until, input int abort_c);
        logic exp_ref;
        r_send = 0; r_shift = 0; r_first_shift = 0; r_last_shift = 0;
        r_done = 0; r_last_done = 0; r_done_bit = -1; r_load = 0; r_ref_err = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            valid_a = (c <= valid_until);
            abort   = (c == abort_c);
            @(negedge clk);
            if (send_a) r_send++;
            exp_ref = send_a && (((c - 1) % (2*CH)) < CH);
            if ((ref_a !== exp_ref) || (chaos_a !== exp_ref)) r_ref_err++;
            if (shift_a) begin
                r_shift++;
                if (r_first_shift == 0) r_first_shift = c;
                r_last_shift = c;
            end
            if (done_a) begin
                r_done++;
                r_last_done = c;
                r_done_bit  = int'(bit_a);
            end
            if (load_a) r_load++;
        end
    endtask

    initial begin
        int e_force, e_send, e_done, e_ready, e_ref, n_shift_b;
        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; frame_len = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready_a), 32'd1);
        check_eq("rst_sending", 32'(send_a), 32'd0);
        check_eq("rst_chip", 32'(chip_a), 32'd0);
        check_eq("rst_bit", 32'(bit_a), 32'd0);
        check_eq("rst_load", 32'(load_a), 32'd0);
        check_eq("rst_ready_b", 32'(ready_b), 32'd1);

        // Single frame, len=2
        accept_a(10'd2, "t1_accept");
        run_a(24, 0, 0);
        check_eq("t1_sending", 32'(r_send), 32'd24);
        check_eq("t1_ref_half", 32'(r_ref_err), 32'd0);
        check_eq("t1_shift_cnt", 32'(r_shift), 32'd2);
        check_eq("t1_shift_first", 32'(r_first_shift), 32'd8);
        check_eq("t1_shift_last", 32'(r_last_shift), 32'd16);
        check_eq("t1_done_cnt", 32'(r_done), 32'd1);
        check_eq("t1_done_cyc", 32'(r_last_done), 32'd24);
        check_eq("t1_ready_last", 32'(ready_a), 32'd1);
        run_a(1, 0, 0);
        check_eq("t1_idle_send", 32'(r_send), 32'd0);
        check_eq("t1_idle_ready", 32'(ready_a), 32'd1);

        // Back-to-back frames with valid held until the second accept
        accept_a(10'd2, "t2_accept");
        run_a(48, 24, 0);
        check_eq("t2_sending", 32'(r_send), 32'd48);
        check_eq("t2_load_cnt", 32'(r_load), 32'd1);
        check_eq("t2_done_cnt", 32'(r_done), 32'd2);
        check_eq("t2_done_last", 32'(r_last_done), 32'd48);
        check_eq("t2_shift_cnt", 32'(r_shift), 32'd4);
        check_eq("t2_ref_half", 32'(r_ref_err), 32'd0);
        run_a(1, 0, 0);
        check_eq("t2_idle_send", 32'(r_send), 32'd0);

        // Abort at bit 1 chip 3, len=5
        accept_a(10'd5, "t4_accept");
        run_a(12, 0, 12);
        check_eq("t4_done", 32'(done_a), 32'd1);
        check_eq("t4_no_shift", 32'(shift_a), 32'd0);
        check_eq("t4_no_ready", 32'(ready_a), 32'd0);
        check_eq("t4_bit", 32'(bit_a), 32'd1);
        check_eq("t4_chip", 32'(chip_a), 32'd3);
        check_eq("t4_shift_cnt", 32'(r_shift), 32'd1);
        run_a(1, 0, 0);
        check_eq("t4_idle_ready", 32'(ready_a), 32'd1);
        check_eq("t4_idle_send", 32'(send_a), 32'd0);
        check_eq("t4_idle_done", 32'(r_done), 32'd0);

        // Synchronous reset mid-symbol, then accept with valid already high
        accept_a(10'd3, "t5_accept");
        run_a(5, 0, 0);
        check_eq("t5_chip_pre", 32'(chip_a), 32'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_ready", 32'(ready_a), 32'd1);
        check_eq("t5_send", 32'(send_a), 32'd0);
        check_eq("t5_chip", 32'(chip_a), 32'd0);
        check_eq("t5_bit", 32'(bit_a), 32'd0);
        check_eq("t5_done", 32'(done_a), 32'd0);
        check_eq("t5_ref", 32'(ref_a), 32'd0);
        rst_n = 1'b1; valid_a = 1'b1; frame_len = 10'd1;
        @(negedge clk);
        check_eq("t5_reaccept", 32'(load_a), 32'd1);
        run_a(16, 0, 0);
        check_eq("t5_sending", 32'(r_send), 32'd16);
        check_eq("t5_done_cyc", 32'(r_last_done), 32'd16);
        check_eq("t5_shift_cnt", 32'(r_shift), 32'd1);

        // Preamble + guard on B, len=0
        @(posedge clk); #1;
        valid_b = 1'b1; frame_len = 10'd0;
        @(negedge clk);
        check_eq("t3_accept", 32'(load_b), 32'd1);
        e_force = 0; e_send = 0; e_done = 0; e_ready = 0; e_ref = 0; n_shift_b = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            valid_b = 1'b0;
            @(negedge clk);
            if (force_b !== (c <= 16)) e_force++;
            if (send_b !== (c <= 24)) e_send++;
            if (done_b !== (c == 24)) e_done++;
            if (ready_b !== (c >= 30)) e_ready++;
            if ((ref_b !== ((c <= 24) && (((c - 1) % (2*CH)) < CH))) || (chaos_b !== ref_b)) e_ref++;
            if (shift_b) n_shift_b++;
        end
        check_eq("t3_force_one", 32'(e_force), 32'd0);
        check_eq("t3_sending", 32'(e_send), 32'd0);
        check_eq("t3_done", 32'(e_done), 32'd0);
        check_eq("t3_ready", 32'(e_ready), 32'd0);
        check_eq("t3_ref_half", 32'(e_ref), 32'd0);
        check_eq("t3_no_shift", 32'(n_shift_b), 32'd0);

        // Maximum length frame
        accept_a(10'd1023, "t6_accept");
        run_a(1024 * 2 * CH, 0, 0);
        check_eq("t6_shift_cnt", 32'(r_shift), 32'd1023);
        check_eq("t6_done_cnt", 32'(r_done), 32'd1);
        check_eq("t6_done_cyc", 32'(r_last_done), 32'd8192);
        check_eq("t6_done_bit", 32'(r_done_bit), 32'd1023);
        run_a(1, 0, 0);
        check_eq("t6_idle_ready", 32'(ready_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
